ipd_scheduler: RTL and testbench
================================

IPD_SCHEDULER -- requirements
Module: ipd_scheduler

Interface
REQ-001 Parameter SAMPLE_DIV, default 500000, clk cycles per control sample period (minimum 64).
REQ-002 Parameter CALC_CYC, default 4, number of clk cycles reserved for the I-PD arithmetic settle window (range 1..15).
REQ-003 Parameter WDOG_CYC, default 200000, clk cycles allowed from adc_start to ADC completion.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port run  input  1  level; 1 = periodic sampling enabled.
REQ-007 Port adc_done  input  1  ADC receiver ready level; asynchronous to clk (ADC capture clock domain).
REQ-008 Port adc_start  output  1  start-conversion request to the ADC receiver, held until adc_done seen high.
REQ-009 Port cap_en  output  1  one-cycle pulse loading the y(k)/ref(k) pipeline registers.
REQ-010 Port calc_en  output  1  one-cycle pulse advancing the integrator/derivative state registers.
REQ-011 Port pwm_load  output  1  one-cycle pulse loading the new duty value into the PWM.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port overrun  output  1  sticky flag: sample tick occurred while busy.
REQ-014 Port timeout  output  1  sticky flag: watchdog expired.
REQ-015 Port sample_cnt  output  16  completed-sample counter, wraps 0xFFFF -> 0x0000.

Function
REQ-016 adc_done shall pass a 2-flop synchronizer; the rising edge of the synchronized value is "done_rise".
REQ-017 A period counter shall count 0..SAMPLE_DIV-1 while run=1, issuing a one-cycle tick at terminal count; run=0 holds it at 0.
REQ-018 States: IDLE, START, WAIT_RDY, CAPTURE, CALC, UPDATE.
REQ-019 IDLE -> START on tick; START asserts adc_start and moves to WAIT_RDY next cycle.
REQ-020 WAIT_RDY keeps adc_start=1; on done_rise deasserts adc_start and moves to CAPTURE.
REQ-021 CAPTURE lasts one cycle asserting cap_en, then CALC.
REQ-022 CALC asserts calc_en in its first cycle only and lasts exactly CALC_CYC cycles, then UPDATE.
REQ-023 UPDATE lasts one cycle asserting pwm_load, increments sample_cnt, returns to IDLE.
REQ-024 Latency done_rise -> pwm_load shall be exactly CALC_CYC+2 clk cycles.
REQ-025 A tick while busy=1 shall set overrun and be discarded (no queued sample).
REQ-026 run falling mid-sequence shall not abort; the sequence completes, no new tick follows.
REQ-027 cap_en, calc_en, pwm_load shall be mutually exclusive and never asserted outside their states.
REQ-028 overrun and timeout clear only on rst or on the cycle run rises 0->1.

Reset
REQ-029 On rst: state IDLE, period counter 0, synchronizer 0, all outputs 0, sample_cnt 0.
REQ-030 rst asserted mid-sequence shall drop adc_start and all pulses immediately (asynchronously).

Configuration
REQ-031 Macro IPD_SCHED_WDOG_EN defined: a watchdog counts in WAIT_RDY; reaching WDOG_CYC sets timeout, drops adc_start, returns to IDLE without cap_en/pwm_load.
REQ-032 IPD_SCHED_WDOG_EN undefined: WAIT_RDY waits indefinitely, no watchdog logic, timeout tied 0.

Structure
REQ-033 State encoding enumeration and default parameter constants shall live in shared package ipd_pkg.
REQ-034 The period counter shall be sub-module sample_tick_gen (count, tick, run hold); FSM stays in ipd_scheduler.

Verification
REQ-035 SAMPLE_DIV=100, run=1, adc_done rises 20 cycles after adc_start -> cap_en, calc_en, pwm_load in order, pwm_load CALC_CYC+2 cycles after done_rise, sample_cnt=1.
REQ-036 adc_done delayed 150 cycles with SAMPLE_DIV=100 -> overrun=1, exactly one pwm_load per completed sequence.
REQ-037 IPD_SCHED_WDOG_EN, WDOG_CYC=50, adc_done held 0 -> timeout=1 at 50 cycles, adc_start=0, state IDLE, no pwm_load.
REQ-038 rst pulsed during CALC -> all outputs 0 same cycle, sample_cnt=0, sequence resumes on next tick after release.
REQ-039 run cleared during WAIT_RDY -> sequence completes with pwm_load, no further adc_start; run re-raised clears overrun/timeout.
REQ-040 Preload sample_cnt path to 0xFFFF (65535 samples, SAMPLE_DIV=64) -> next pwm_load wraps sample_cnt to 0x0000.

Source files
------------

// File: rtl/ipd_pkg.sv
// Shared definitions for the I-PD control-loop sample scheduler.
// Holds the scheduler state encoding and the default timing constants
// used by ipd_scheduler and sample_tick_gen.
package ipd_pkg;

  // Default clk cycles per control sample period.
  localparam int DEF_SAMPLE_DIV = 500000;
  // Default settle window for the I-PD arithmetic, in clk cycles.
  localparam int DEF_CALC_CYC   = 4;
  // Default clk cycles allowed between adc_start and ADC completion.
  localparam int DEF_WDOG_CYC   = 200000;

  // Scheduler sequence states. The values are visible on the debug port,
  // so they are pinned explicitly.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_RDY = 3'd2,
    CAPTURE  = 3'd3,
    CALC     = 3'd4,
    UPDATE   = 3'd5
  } ipd_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample period generator for the I-PD scheduler.
// Counts 0..SAMPLE_DIV-1 while run_i is high and raises tick_o for the one
// cycle the count sits at its terminal value. Dropping run_i returns the
// count to 0 and holds it there, so the first tick after run_i rises always
// arrives a full period later.
module sample_tick_gen
  import ipd_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [31:0] LAST = 32'(SAMPLE_DIV - 1);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: hold at zero while stopped, wrap at the terminal value.
  always_comb begin
    count_d = count_q;
    if (!run_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 32'd1;
    end
  end

  // Period count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = run_i && (count_q == LAST);

endmodule

// File: rtl/ipd_scheduler.sv
// I-PD control-loop sample scheduler.
// Each sample period it requests an ADC conversion, waits for the ADC to
// report completion, then pulses the capture, calculate and PWM-load
// strobes that walk the I-PD datapath through one control update.
//
// ADC handshake: adc_start is a level request that rises when a sample is
// launched and stays high until the synchronized adc_done is seen rising;
// the request drops on the same edge that enters CAPTURE. adc_done is only
// acted on as a rising edge, so the ADC must return it low before it can
// signal the next completion.
//
// Build option: define IPD_SCHED_WDOG_EN to add a WAIT_RDY watchdog. When
// defined, an ADC that has not answered WDOG_CYC cycles after adc_start rose
// sets the sticky timeout flag and the sequence is abandoned without any
// capture or PWM update. When undefined there is no watchdog and timeout is
// tied low.
module ipd_scheduler
  import ipd_pkg::*;
#(
  parameter int          SAMPLE_DIV      = DEF_SAMPLE_DIV,
  parameter int          CALC_CYC        = DEF_CALC_CYC,
  parameter int          WDOG_CYC        = DEF_WDOG_CYC,
  // Reset value of the completed-sample counter; normally zero.
  parameter logic [15:0] SAMPLE_CNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        adc_done,
  output logic        adc_start,
  output logic        cap_en,
  output logic        calc_en,
  output logic        pwm_load,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  output logic [15:0] sample_cnt,
  output logic [2:0]  state_dbg
);

  // Reject parameter sets the sequencing cannot honour.
  if (SAMPLE_DIV < 64 || CALC_CYC < 1 || CALC_CYC > 15 || WDOG_CYC < 2) begin : g_bad_params
    $error("ipd_scheduler: parameter out of range");
  end

  localparam logic [3:0] CALC_LAST = 4'(CALC_CYC - 1);

  logic       tick;
  logic       sync1_q;
  logic       sync2_q;
  logic       done_prev_q;
  logic       done_rise;
  logic       run_prev_q;
  logic       run_rise;

  ipd_state_e  state_q;
  logic        adc_start_q;
  logic        cap_en_q;
  logic        calc_en_q;
  logic        pwm_load_q;
  logic        busy_q;
  logic        overrun_q;
  logic [15:0] sample_cnt_q;
  logic [3:0]  calc_cnt_q;

`ifdef IPD_SCHED_WDOG_EN
  // The watchdog count is 0 in the START cycle, so matching WDOG_CYC-1
  // makes timeout visible exactly WDOG_CYC cycles after adc_start rose.
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);
  logic [31:0] wdog_q;
  logic        timeout_q;
`endif

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .tick_o (tick)
  );

  // Bring adc_done into the clk domain and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      sync1_q     <= adc_done;
      sync2_q     <= sync1_q;
      done_prev_q <= sync2_q;
    end
  end

  assign done_rise = sync2_q && !done_prev_q;

  // Remember the last run level so a 0->1 transition can clear the sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_prev_q <= 1'b0;
    end else begin
      run_prev_q <= run;
    end
  end

  assign run_rise = run && !run_prev_q;

  // Sequence FSM with registered strobes, status flags and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      adc_start_q  <= 1'b0;
      cap_en_q     <= 1'b0;
      calc_en_q    <= 1'b0;
      pwm_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= SAMPLE_CNT_INIT;
      calc_cnt_q   <= '0;
`ifdef IPD_SCHED_WDOG_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; they are re-asserted only by a transition below.
      cap_en_q   <= 1'b0;
      calc_en_q  <= 1'b0;
      pwm_load_q <= 1'b0;

      // A tick that lands mid-sequence is dropped, only the flag remembers it.
      if (run_rise) begin
        overrun_q <= 1'b0;
      end else if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

`ifdef IPD_SCHED_WDOG_EN
      if (run_rise) begin
        timeout_q <= 1'b0;
      end
`endif

      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q     <= START;
            adc_start_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef IPD_SCHED_WDOG_EN
            wdog_q      <= '0;
`endif
          end
        end

        START: begin
          state_q <= WAIT_RDY;
`ifdef IPD_SCHED_WDOG_EN
          wdog_q  <= wdog_q + 32'd1;
`endif
        end

        WAIT_RDY: begin
          // Completion wins over a watchdog expiry landing on the same cycle.
          if (done_rise) begin
            state_q     <= CAPTURE;
            adc_start_q <= 1'b0;
            cap_en_q    <= 1'b1;
`ifdef IPD_SCHED_WDOG_EN
          end else if (wdog_q == WDOG_LAST) begin
            state_q     <= IDLE;
            adc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
          end else begin
            wdog_q      <= wdog_q + 32'd1;
`endif
          end
        end

        CAPTURE: begin
          state_q    <= CALC;
          calc_en_q  <= 1'b1;
          calc_cnt_q <= '0;
        end

        CALC: begin
          // calc_en only fires on entry; the rest of the window lets the
          // datapath settle before the PWM picks up the new duty.
          if (calc_cnt_q == CALC_LAST) begin
            state_q      <= UPDATE;
            pwm_load_q   <= 1'b1;
            sample_cnt_q <= sample_cnt_q + 16'd1;
          end else begin
            calc_cnt_q <= calc_cnt_q + 4'd1;
          end
        end

        UPDATE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          adc_start_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign adc_start  = adc_start_q;
  assign cap_en     = cap_en_q;
  assign calc_en    = calc_en_q;
  assign pwm_load   = pwm_load_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign sample_cnt = sample_cnt_q;
  assign state_dbg  = state_q;

`ifdef IPD_SCHED_WDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ipd_scheduler.sv
// Directed bench for ipd_scheduler.
// The main instance runs with a 100-cycle sample period; a second instance
// with a 64-cycle period and a sample counter starting at 0xFFFF covers the
// counter wrap and, when IPD_SCHED_WDOG_EN is defined, the watchdog.
module tb_ipd_scheduler;
  import ipd_pkg::*;

  localparam int CALC_CYC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- DUT signals ----------------
  logic        run, adc_done;
  logic        d_adc_start, d_cap_en, d_calc_en, d_pwm_load, d_busy, d_overrun, d_timeout;
  logic [15:0] d_sample_cnt;
  logic [2:0]  d_state;

  logic        run_w, adc_done_w;
  logic        w_adc_start, w_cap_en, w_calc_en, w_pwm_load, w_busy, w_overrun, w_timeout;
  logic [15:0] w_sample_cnt;
  logic [2:0]  w_state;

  ipd_scheduler #(
    .SAMPLE_DIV (100), .CALC_CYC (CALC_CYC), .WDOG_CYC (1000), .SAMPLE_CNT_INIT (16'h0000)
  ) u_dut (
    .clk (clk), .rst (rst), .run (run), .adc_done (adc_done),
    .adc_start (d_adc_start), .cap_en (d_cap_en), .calc_en (d_calc_en), .pwm_load (d_pwm_load),
    .busy (d_busy), .overrun (d_overrun), .timeout (d_timeout),
    .sample_cnt (d_sample_cnt), .state_dbg (d_state)
  );

  ipd_scheduler #(
    .SAMPLE_DIV (64), .CALC_CYC (CALC_CYC), .WDOG_CYC (50), .SAMPLE_CNT_INIT (16'hFFFF)
  ) u_wrap (
    .clk (clk), .rst (rst), .run (run_w), .adc_done (adc_done_w),
    .adc_start (w_adc_start), .cap_en (w_cap_en), .calc_en (w_calc_en), .pwm_load (w_pwm_load),
    .busy (w_busy), .overrun (w_overrun), .timeout (w_timeout),
    .sample_cnt (w_sample_cnt), .state_dbg (w_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic [15:0] sb_exp;
  int          w_pwm_cnt = 0;
  int          w_cap_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every pwm_load must match a queued sample; the counter is compared a cycle later.
  always @(negedge clk) begin
    if (d_pwm_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pwm_unexpected", 32'd1, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        @(negedge clk);
        check("sample_cnt", {16'd0, d_sample_cnt}, {16'd0, sb_exp});
      end
    end
  end

  // Strobes are mutually exclusive and only appear in their own state.
  always @(negedge clk) begin
    check("pulse_excl",
          {31'd0, ($onehot0({d_cap_en, d_calc_en, d_pwm_load})
                   && (!d_cap_en   || d_state == CAPTURE)
                   && (!d_calc_en  || d_state == CALC)
                   && (!d_pwm_load || d_state == UPDATE))},
          32'd1);
  end

  always @(negedge clk) begin
    if (w_pwm_load === 1'b1) w_pwm_cnt++;
    if (w_cap_en === 1'b1)   w_cap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start(input string tag, input int max, output int at_cyc);
    int n = 0;
    while (d_adc_start !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, {31'd0, d_adc_start}, 32'd1);
    at_cyc = cycle;
  endtask

  task automatic wait_start_w(input string tag, input int max, output int at_cyc);
    int n = 0;
    while (w_adc_start !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, {31'd0, w_adc_start}, 32'd1);
    at_cyc = cycle;
  endtask

  // Raise adc_done after delay cycles and follow the strobes to IDLE.
  // adc_done set at negedge N: synchronized edge during N+2, CAPTURE at N+3,
  // pwm_load at N+2+CALC_CYC+2.
  task automatic adc_seq(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    adc_done = 1'b1;
    @(negedge clk);
    check({tag, "_hold1"}, {30'd0, d_adc_start, d_cap_en}, 32'b10);
    @(negedge clk);
    check({tag, "_hold2"}, {30'd0, d_adc_start, d_cap_en}, 32'b10);
    @(negedge clk);
    check({tag, "_capture"}, {26'd0, d_adc_start, d_cap_en, d_calc_en, d_state},
          {26'd0, 3'b010, 3'(CAPTURE)});
    @(negedge clk);
    check({tag, "_calc_en"}, {27'd0, d_cap_en, d_calc_en, d_state}, {27'd0, 2'b01, 3'(CALC)});
    for (int i = 1; i < CALC_CYC; i++) begin
      @(negedge clk);
      check({tag, "_calc_hold"}, {27'd0, d_calc_en, d_pwm_load, d_state}, {27'd0, 2'b00, 3'(CALC)});
    end
    @(negedge clk);
    check({tag, "_pwm_load"}, {28'd0, d_pwm_load, d_state}, {28'd0, 1'b1, 3'(UPDATE)});
    @(negedge clk);
    check({tag, "_idle"}, {27'd0, d_pwm_load, d_busy, d_state}, {27'd0, 2'b00, 3'(IDLE)});
    adc_done = 1'b0;
  endtask

  task automatic push_sample();
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back(exp_cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, ts, prev, n;
    logic saw;
    rst = 1'b1; run = 1'b0; adc_done = 1'b0; run_w = 1'b0; adc_done_w = 1'b0;
    exp_cnt = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {25'd0, d_adc_start, d_cap_en, d_calc_en, d_pwm_load, d_busy, d_overrun, d_timeout}, 32'd0);
    check("rst_sample_cnt", {16'd0, d_sample_cnt}, 32'd0);
    check("rst_state", {29'd0, d_state}, {29'd0, 3'(IDLE)});
    check("rst_wrap_init", {16'd0, w_sample_cnt}, 32'h0000FFFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First sample: full period after run rises, ADC answers after 20 cycles.
    run = 1'b1; t0 = cycle;
    wait_start("s1", 200, ts);
    check("s1_tick_latency", ts - t0, 32'd100);
    check("s1_start_state", {28'd0, d_busy, d_state}, {28'd0, 1'b1, 3'(START)});
    push_sample();
    adc_seq("s1", 20);

    // Second sample one period later, short ADC delay.
    prev = ts;
    wait_start("s2", 200, ts);
    check("s2_period", ts - prev, 32'd100);
    push_sample();
    adc_seq("s2", 5);
    check("s2_no_overrun", {31'd0, d_overrun}, 32'd0);

    // Slow ADC: a tick lands while busy and must be dropped, not queued.
    prev = ts;
    wait_start("s3", 200, ts);
    check("s3_period", ts - prev, 32'd100);
    push_sample();
    adc_seq("s3", 150);
    check("s3_overrun", {31'd0, d_overrun}, 32'd1);
    prev = ts;
    wait_start("s3b", 300, ts);
    check("s3_discarded_tick", ts - prev, 32'd200);
    push_sample();
    adc_seq("s3b", 10);

    // Reset in the middle of CALC.
    prev = ts;
    wait_start("s4", 200, ts);
    check("s4_period", ts - prev, 32'd100);
    repeat (10) @(negedge clk);
    adc_done = 1'b1;
    repeat (4) @(negedge clk);
    check("s4_in_calc", {28'd0, d_calc_en, d_state}, {28'd0, 1'b1, 3'(CALC)});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("s4_rst_outputs", {25'd0, d_adc_start, d_cap_en, d_calc_en, d_pwm_load, d_busy, d_overrun, d_timeout}, 32'd0);
    check("s4_rst_cnt", {16'd0, d_sample_cnt}, 32'd0);
    check("s4_rst_state", {29'd0, d_state}, {29'd0, 3'(IDLE)});
    adc_done = 1'b0;
    exp_cnt = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; t0 = cycle;
    wait_start("s4b", 200, ts);
    check("s4_resume_latency", ts - t0, 32'd100);
    push_sample();
    adc_seq("s4b", 7);

    // run dropped while waiting on the ADC: finish the sample, then stop.
    prev = ts;
    wait_start("s5", 200, ts);
    check("s5_period", ts - prev, 32'd100);
    repeat (105) @(negedge clk);
    check("s5_overrun_set", {27'd0, d_overrun, d_adc_start, d_state}, {27'd0, 2'b11, 3'(WAIT_RDY)});
    run = 1'b0;
    push_sample();
    adc_seq("s5", 0);
    saw = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (d_adc_start) saw = 1'b1;
    end
    check("s5_no_restart", {31'd0, saw}, 32'd0);
    check("s5_overrun_sticky", {31'd0, d_overrun}, 32'd1);
    run = 1'b1; t0 = cycle;
    @(negedge clk);
    check("s5_flags_cleared", {30'd0, d_overrun, d_timeout}, 32'd0);
    wait_start("s5b", 200, ts);
    check("s5_restart_latency", ts - t0, 32'd100);
    push_sample();
    adc_seq("s5b", 3);
    run = 1'b0;

    // Second instance: watchdog (when built in) and sample counter wrap.
    run_w = 1'b1; t0 = cycle;
    wait_start_w("w1", 200, ts);
    check("w1_tick_latency", ts - t0, 32'd64);
`ifdef IPD_SCHED_WDOG_EN
    repeat (49) @(negedge clk);
    check("wd_before", {30'd0, w_timeout, w_adc_start}, 32'b01);
    @(negedge clk);
    check("wd_expired", {26'd0, w_timeout, w_adc_start, w_busy, w_state}, {26'd0, 3'b100, 3'(IDLE)});
    repeat (3) @(negedge clk);
    check("wd_no_pulses", w_pwm_cnt + w_cap_cnt, 32'd0);
    prev = ts;
    wait_start_w("w2", 200, ts);
    check("w2_period", ts - prev, 32'd64);
`endif
    check("wrap_before", {16'd0, w_sample_cnt}, 32'h0000FFFF);
    repeat (4) @(negedge clk);
    adc_done_w = 1'b1;
    n = 0;
    while (w_pwm_load !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wrap_pwm_seen", {31'd0, w_pwm_load}, 32'd1);
    @(negedge clk);
    check("wrap_sample_cnt", {16'd0, w_sample_cnt}, 32'd0);
    check("wrap_pwm_count", w_pwm_cnt, 32'd1);
`ifdef IPD_SCHED_WDOG_EN
    check("wrap_timeout_sticky", {31'd0, w_timeout}, 32'd1);
`else
    check("wrap_timeout_tied", {31'd0, w_timeout}, 32'd0);
`endif
    adc_done_w = 1'b0;
    run_w = 1'b0;

    // ---------------- final report ----------------
    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
